// File: rtl/memory_32_4_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : memory_32_4_fifo_ctrl
// Description : Stream FIFO controller in front of an external 16 x 32-bit
//               memory with a 2-cycle registered read. Pushed words go to
//               the memory write port. They are read back in order into a
//               3-entry output buffer that drives the read stream.
// Ports       : clk            - rising-edge clock
//               reset          - synchronous, active-low reset
//               in_vld/in_data/in_rdy    - write stream (push on vld & rdy)
//               out_vld/out_data/out_rdy - read stream (pop on vld & rdy)
//               m_wr_vld/m_wr_address/m_wr_data - registered memory write
//               m_rd_address   - memory read address (combinational rd_ptr)
//               m_rd_data      - memory read data, 2 cycles after address
//               level          - stored + in-flight + buffered words (0..19)
// Revision    : 1.0 - initial release
// ============================================================================
module memory_32_4_fifo_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_vld,
    input  logic [31:0] in_data,
    output logic        in_rdy,
    output logic        out_vld,
    output logic [31:0] out_data,
    input  logic        out_rdy,
    output logic        m_wr_vld,
    output logic [3:0]  m_wr_address,
    output logic [31:0] m_wr_data,
    output logic [3:0]  m_rd_address,
    input  logic [31:0] m_rd_data,
    output logic [4:0]  level
);

    localparam logic [4:0] C_MEM_DEPTH  = 5'd16;
    localparam logic [2:0] C_OBUF_DEPTH = 3'd3;

    // Memory-side state
    logic [3:0]  r_wr_ptr;
    logic [3:0]  r_rd_ptr;
    logic [4:0]  r_stored;     // pushed but not yet read-issued
    logic        r_wr_vld;
    logic [3:0]  r_wr_addr;
    logic [31:0] r_wr_data;

    // Read pipeline: bit 0 = issued last cycle, bit 1 = data arrives this cycle
    logic [1:0]  r_infl;

    // Output buffer, circular over three entries
    logic [31:0] r_obuf [0:2];
    logic [1:0]  r_ob_wr;
    logic [1:0]  r_ob_rd;
    logic [1:0]  r_ob_cnt;

    logic        w_push;
    logic        w_pop;
    logic        w_eligible;
    logic [2:0]  w_outstanding;
    logic [2:0]  w_credit_used;
    logic        w_issue;

    function automatic logic [1:0] f_inc3(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    assign in_rdy  = reset && (r_stored < C_MEM_DEPTH);
    assign out_vld = (r_ob_cnt != 2'd0);
    assign out_data = r_obuf[r_ob_rd];

    assign w_push = in_vld && in_rdy;
    assign w_pop  = out_vld && out_rdy;

    // A word pushed last cycle is being written right now (r_wr_vld), so it
    // is still counted in r_stored but cannot be read yet.
    assign w_eligible = (r_stored > {4'd0, r_wr_vld});

    // Every read in flight owns an output-buffer slot. A pop this cycle frees
    // a slot at the same edge, so it is credited back immediately; without
    // this, a full-rate stream would stall every fourth cycle.
    assign w_outstanding = {1'b0, r_ob_cnt} + {2'd0, r_infl[0]} + {2'd0, r_infl[1]};
    assign w_credit_used = w_outstanding - {2'd0, w_pop};
    assign w_issue = reset && w_eligible && (w_credit_used < C_OBUF_DEPTH);

    assign m_rd_address = r_rd_ptr;
    assign m_wr_vld     = r_wr_vld;
    assign m_wr_address = r_wr_addr;
    assign m_wr_data    = r_wr_data;

    assign level = r_stored + {3'd0, r_ob_cnt} + {4'd0, r_infl[0]} + {4'd0, r_infl[1]};

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr  <= 4'd0;
            r_rd_ptr  <= 4'd0;
            r_stored  <= 5'd0;
            r_wr_vld  <= 1'b0;
            r_wr_addr <= 4'd0;
            r_wr_data <= 32'd0;
            r_infl    <= 2'b00;
            r_ob_wr   <= 2'd0;
            r_ob_rd   <= 2'd0;
            r_ob_cnt  <= 2'd0;
        end else begin
            r_wr_vld <= w_push;
            if (w_push) begin
                r_wr_addr <= r_wr_ptr;
                r_wr_data <= in_data;
                r_wr_ptr  <= r_wr_ptr + 4'd1;
            end
            if (w_issue) begin
                r_rd_ptr <= r_rd_ptr + 4'd1;
            end
            r_stored <= r_stored + {4'd0, w_push} - {4'd0, w_issue};
            r_infl   <= {r_infl[0], w_issue};
            if (r_infl[1]) begin
                r_ob_wr <= f_inc3(r_ob_wr);
            end
            if (w_pop) begin
                r_ob_rd <= f_inc3(r_ob_rd);
            end
            r_ob_cnt <= r_ob_cnt + {1'b0, r_infl[1]} - {1'b0, w_pop};
        end
    end

    // Buffer storage needs no reset: the counters alone decide what is valid,
    // so data returning across a reset lands in a slot that is never read.
    always_ff @(posedge clk) begin
        if (r_infl[1]) begin
            r_obuf[r_ob_wr] <= m_rd_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_32_4_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_32_4_fifo_ctrl
// Description : Self-checking bench for memory_32_4_fifo_ctrl. Holds a
//               16 x 32 memory with a 2-cycle read, a count/timestamp
//               reference model compared every cycle, and directed tests
//               with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_32_4_fifo_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_vld;
    logic [31:0] in_data;
    logic        in_rdy;
    logic        out_vld;
    logic [31:0] out_data;
    logic        out_rdy;
    logic        m_wr_vld;
    logic [3:0]  m_wr_address;
    logic [31:0] m_wr_data;
    logic [3:0]  m_rd_address;
    logic [31:0] m_rd_data;
    logic [4:0]  level;

    always #5 clk = ~clk;

    memory_32_4_fifo_ctrl dut (
        .clk          (clk),
        .reset        (reset),
        .in_vld       (in_vld),
        .in_data      (in_data),
        .in_rdy       (in_rdy),
        .out_vld      (out_vld),
        .out_data     (out_data),
        .out_rdy      (out_rdy),
        .m_wr_vld     (m_wr_vld),
        .m_wr_address (m_wr_address),
        .m_wr_data    (m_wr_data),
        .m_rd_address (m_rd_address),
        .m_rd_data    (m_rd_data),
        .level        (level)
    );

    // External memory: address registered, data registered one cycle later
    logic [31:0] mem [0:15];
    logic [3:0]  rd_addr_q;
    always @(posedge clk) begin
        if (m_wr_vld) mem[m_wr_address] <= m_wr_data;
        rd_addr_q <= m_rd_address;
        m_rd_data <= mem[rd_addr_q];
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------------
    // Reference model: words are tracked by push/issue/pop counts and the
    // cycle each was pushed and read-issued.
    // ------------------------------------------------------------------
    int          t = 0;
    logic        armed = 1'b0;
    int          n_push, n_issue, n_pop;
    int          push_cyc  [1024];
    int          issue_cyc [1024];
    logic [31:0] wdata     [1024];
    logic        e_wr_vld;
    logic [3:0]  e_wr_addr;
    logic [31:0] e_wr_data;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data;
    logic [31:0] got_q [$];
    int          got_t [$];

    initial begin : model
        logic e_rdy, e_ovld, m_pop, m_issue, m_push;
        n_push = 0; n_issue = 0; n_pop = 0;
        e_wr_vld = 1'b0; e_wr_addr = 4'd0; e_wr_data = 32'd0;
        forever begin
            @(negedge clk);
            if (armed) begin
                e_rdy  = reset && ((n_push - n_issue) < 16);
                e_ovld = (n_pop < n_issue) && (issue_cyc[n_pop % 1024] + 3 <= t);
                chk("in_rdy",   {31'd0, in_rdy},   {31'd0, e_rdy});
                chk("out_vld",  {31'd0, out_vld},  {31'd0, e_ovld});
                if (e_ovld) chk("out_data", out_data, wdata[n_pop % 1024]);
                chk("level",    {27'd0, level},    32'(n_push - n_pop));
                chk("m_wr_vld", {31'd0, m_wr_vld}, {31'd0, e_wr_vld});
                chk("m_wr_address", {28'd0, m_wr_address}, {28'd0, e_wr_addr});
                chk("m_wr_data", m_wr_data, e_wr_data);
                chk("m_rd_address", {28'd0, m_rd_address}, 32'(n_issue % 16));
                if (prev_hold && reset) begin
                    chk("hold_vld",  {31'd0, out_vld}, 32'd1);
                    chk("hold_data", out_data, prev_data);
                end
                prev_hold = reset && out_vld && !out_rdy;
                prev_data = out_data;
                if (reset && out_vld && out_rdy) begin
                    got_q.push_back(out_data);
                    got_t.push_back(t);
                end
                if (reset) begin
                    m_pop   = e_ovld && out_rdy;
                    m_issue = (n_issue < n_push) && (push_cyc[n_issue % 1024] + 2 <= t)
                              && ((n_issue - n_pop - int'(m_pop)) < 3);
                    m_push  = in_vld && e_rdy;
                    if (m_push) begin
                        wdata[n_push % 1024]    = in_data;
                        push_cyc[n_push % 1024] = t;
                        e_wr_addr = 4'(n_push % 16);
                        e_wr_data = in_data;
                        n_push++;
                    end
                    e_wr_vld = m_push;
                    if (m_pop) n_pop++;
                    if (m_issue) begin
                        issue_cyc[n_issue % 1024] = t;
                        n_issue++;
                    end
                end else begin
                    n_push = 0; n_issue = 0; n_pop = 0;
                    e_wr_vld = 1'b0; e_wr_addr = 4'd0; e_wr_data = 32'd0;
                end
            end else if (!reset) begin
                armed = 1'b1;
            end
            t++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r);
        in_vld  = v;
        in_data = d;
        out_rdy = r;
    endtask

    task automatic wait_empty(input string name, input int budget);
        for (int i = 0; i < budget && level != 5'd0; i++) tick();
        chk(name, {27'd0, level}, 32'd0);
    endtask

    initial begin : timeout
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int k;
        int t0;
        reset = 1'b0;
        drive(1'b0, 32'd0, 1'b0);
        tick(); tick();
        #1;
        chk("rst_level",   {27'd0, level},    32'd0);
        chk("rst_out_vld", {31'd0, out_vld},  32'd0);
        chk("rst_in_rdy",  {31'd0, in_rdy},   32'd0);
        chk("rst_wr_vld",  {31'd0, m_wr_vld}, 32'd0);
        chk("rst_wr_addr", {28'd0, m_wr_address}, 32'd0);
        chk("rst_wr_data", m_wr_data, 32'd0);
        tick();

        // Single word, pushed in the first cycle out of reset
        reset = 1'b1;
        drive(1'b1, 32'hDEADBEEF, 1'b1);
        #1;
        chk("sw_first_rdy", {31'd0, in_rdy}, 32'd1);
        t0 = t;
        got_q.delete(); got_t.delete();
        tick();
        drive(1'b0, 32'd0, 1'b1);
        #1;
        chk("sw_wr_vld",  {31'd0, m_wr_vld}, 32'd1);
        chk("sw_wr_addr", {28'd0, m_wr_address}, 32'd0);
        chk("sw_wr_data", m_wr_data, 32'hDEADBEEF);
        tick(); #1;
        chk("sw_c2_level", {27'd0, level}, 32'd1);
        chk("sw_c2_rd_addr", {28'd0, m_rd_address}, 32'd0);
        tick(); #1;
        chk("sw_c3_vld", {31'd0, out_vld}, 32'd0);
        tick(); #1;
        chk("sw_c4_vld", {31'd0, out_vld}, 32'd0);
        chk("sw_c4_rd_addr", {28'd0, m_rd_address}, 32'd1);
        tick(); #1;
        chk("sw_c5_vld",  {31'd0, out_vld}, 32'd1);
        chk("sw_c5_data", out_data, 32'hDEADBEEF);
        tick(); #1;
        chk("sw_c6_vld",   {31'd0, out_vld}, 32'd0);
        chk("sw_c6_level", {27'd0, level}, 32'd0);
        chk("sw_pop_cycle", 32'(got_t.size() > 0 ? got_t[0] - t0 : -1), 32'd5);

        // Fill: nothing drains, 19 words fit before in_rdy drops
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 32'(i), 1'b0);
            tick();
        end
        k = 16;
        for (int c = 0; c < 10 && k < 19; c++) begin
            drive(1'b1, 32'(k), 1'b0);
            #1;
            if (in_rdy) k++;
            tick();
        end
        chk("fill_accepted", 32'(k), 32'd19);
        drive(1'b1, 32'h0BAD0BAD, 1'b0);
        tick(); tick(); tick();
        #1;
        chk("fill_level",  {27'd0, level},   32'd19);
        chk("fill_in_rdy", {31'd0, in_rdy},  32'd0);
        chk("fill_out_vld", {31'd0, out_vld}, 32'd1);
        chk("fill_head",   out_data, 32'd0);
        got_q.delete(); got_t.delete();
        drive(1'b0, 32'd0, 1'b1);
        wait_empty("fill_drain", 80);
        chk("fill_count", 32'(got_q.size()), 32'd19);
        for (int i = 0; i < got_q.size(); i++) chk("fill_order", got_q[i], 32'(i));

        // Wrap: 40 words at full rate
        got_q.delete(); got_t.delete();
        for (int i = 0; i < 40; i++) begin
            drive(1'b1, 32'(i), 1'b1);
            #1;
            if (i == 0) t0 = t;
            if (!in_rdy) chk("wrap_in_rdy", {31'd0, in_rdy}, 32'd1);
            tick();
        end
        drive(1'b0, 32'd0, 1'b1);
        wait_empty("wrap_drain", 40);
        chk("wrap_count", 32'(got_q.size()), 32'd40);
        for (int i = 0; i < got_q.size(); i++) chk("wrap_order", got_q[i], 32'(i));
        if (got_t.size() == 40) begin
            chk("wrap_first_latency", 32'(got_t[0] - t0), 32'd5);
            chk("wrap_back_to_back", 32'(got_t[39] - got_t[0]), 32'd39);
        end

        // Backpressure: out_rdy toggles while pushes continue
        got_q.delete(); got_t.delete();
        k = 0;
        for (int c = 0; c < 80 && k < 30; c++) begin
            drive(1'b1, 32'h100 + 32'(k), (c % 2) == 0);
            #1;
            if (in_rdy) k++;
            tick();
        end
        drive(1'b0, 32'd0, 1'b1);
        wait_empty("bp_drain", 80);
        chk("bp_count", 32'(got_q.size()), 32'd30);
        for (int i = 0; i < got_q.size(); i++) chk("bp_order", got_q[i], 32'h100 + 32'(i));

        // Mid-run reset with level 7 and two reads in flight
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'd200 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b0, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        #1;
        chk("mr_buffered", {27'd0, level}, 32'd3);
        for (int i = 3; i < 7; i++) begin
            drive(1'b1, 32'd200 + 32'(i), 1'b0);
            tick();
        end
        drive(1'b1, 32'd207, 1'b1);
        tick();
        drive(1'b1, 32'd208, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b0);
        reset = 1'b0;
        #1;
        chk("mr_pre_level", {27'd0, level}, 32'd7);
        chk("mr_rst_in_rdy", {31'd0, in_rdy}, 32'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("mr_post_vld",    {31'd0, out_vld}, 32'd0);
        chk("mr_post_level",  {27'd0, level},   32'd0);
        chk("mr_post_in_rdy", {31'd0, in_rdy},  32'd1);
        tick(); #1;
        chk("mr_stale_vld",   {31'd0, out_vld}, 32'd0);
        chk("mr_stale_level", {27'd0, level},   32'd0);
        got_q.delete(); got_t.delete();
        drive(1'b1, 32'h55, 1'b1);
        tick();
        drive(1'b0, 32'd0, 1'b1);
        #1;
        chk("mr_wr_vld",  {31'd0, m_wr_vld}, 32'd1);
        chk("mr_wr_addr", {28'd0, m_wr_address}, 32'd0);
        wait_empty("mr_drain", 20);
        chk("mr_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() > 0) chk("mr_word", got_q[0], 32'h55);

        tick(); tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
